// File: rtl/iob_uart_ctrl.sv
// IOb bus master that initialises a UART slave, then moves bytes between local streams and it.
// Build option: define IOB_UART_CTRL_RX_EN for the receive path; otherwise the block is transmit-only.

module iob_uart_ctrl #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 4,
  parameter int DIV_INIT       = 868,
  parameter int SOFTRESET_ADDR = 0,
  parameter int DIV_ADDR       = 1,
  parameter int TXDATA_ADDR    = 2,
  parameter int TXEN_ADDR      = 3,
  parameter int RXEN_ADDR      = 4,
  parameter int TXREADY_ADDR   = 5,
  parameter int RXREADY_ADDR   = 6,
  parameter int RXDATA_ADDR    = 7
) (
  input  logic                clk,
  input  logic                rst,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready,
  input  logic                tx_valid,
  input  logic [7:0]          tx_data,
  output logic                tx_ready,
  output logic                rx_valid,
  output logic [7:0]          rx_data,
  input  logic                rx_ready,
  output logic                init_done
);

`ifdef IOB_UART_CTRL_RX_EN
  localparam logic RX_EN = 1'b1;
  typedef enum logic [3:0] {
    S_INIT0, S_INIT1, S_INIT2, S_INIT3, S_INIT4,
    S_IDLE, S_TX_POLL, S_TX_WRITE, S_RX_POLL, S_RX_READ
  } state_t;
`else
  localparam logic RX_EN = 1'b0;
  typedef enum logic [3:0] {
    S_INIT0, S_INIT1, S_INIT2, S_INIT3, S_INIT4,
    S_IDLE, S_TX_POLL, S_TX_WRITE
  } state_t;
`endif

  state_t              state_q, state_d;
  logic                m_valid_q, m_valid_d;
  logic [ADDR_W-1:0]   m_address_q, m_address_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [DATA_W/8-1:0] m_wstrb_q, m_wstrb_d;
  logic                tx_full_q, tx_full_d;
  logic [7:0]          tx_byte_q, tx_byte_d;
  logic                init_done_q, init_done_d;

  logic                bus_done, tx_accept, tx_pending;
  logic                req_en, req_we;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic                unused_ok;

`ifdef IOB_UART_CTRL_RX_EN
  logic                rx_valid_q, rx_valid_d;
  logic [7:0]          rx_data_q, rx_data_d;
  logic                last_tx_q, last_tx_d;
  logic                rx_elig;

  assign rx_elig   = ~rx_valid_q;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign unused_ok = ^m_rdata[DATA_W-1:8];
`else
  assign rx_valid  = 1'b0;
  assign rx_data   = 8'h00;
  assign unused_ok = ^{rx_ready, m_rdata[DATA_W-1:1]};
`endif

  assign m_valid   = m_valid_q;
  assign m_address = m_address_q;
  assign m_wdata   = m_wdata_q;
  assign m_wstrb   = m_wstrb_q;
  assign init_done = init_done_q;

  assign bus_done   = m_valid_q & m_ready;
  assign tx_ready   = init_done_q & ~tx_full_q;
  assign tx_accept  = tx_valid & tx_ready;
  // A byte landing this cycle already counts, so TX wins the first grant after init.
  assign tx_pending = tx_full_q | tx_accept;

  always_comb begin
    state_d     = state_q;
    m_valid_d   = m_valid_q;
    m_address_d = m_address_q;
    m_wdata_d   = m_wdata_q;
    m_wstrb_d   = m_wstrb_q;
    tx_full_d   = tx_full_q;
    tx_byte_d   = tx_byte_q;
    init_done_d = init_done_q;
`ifdef IOB_UART_CTRL_RX_EN
    rx_valid_d  = rx_valid_q;
    rx_data_d   = rx_data_q;
    last_tx_d   = last_tx_q;
`endif
    req_en      = 1'b0;
    req_we      = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;

    if (tx_accept) begin
      tx_full_d = 1'b1;
      tx_byte_d = tx_data;
    end
`ifdef IOB_UART_CTRL_RX_EN
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
`endif

    case (state_q)
      S_INIT0: begin
        req_en = 1'b1; req_we = 1'b1;
        req_addr = ADDR_W'(SOFTRESET_ADDR); req_wdata = DATA_W'(1);
        if (bus_done) state_d = S_INIT1;
      end
      S_INIT1: begin
        req_en = 1'b1; req_we = 1'b1;
        req_addr = ADDR_W'(SOFTRESET_ADDR); req_wdata = '0;
        if (bus_done) state_d = S_INIT2;
      end
      S_INIT2: begin
        req_en = 1'b1; req_we = 1'b1;
        req_addr = ADDR_W'(DIV_ADDR); req_wdata = DATA_W'(DIV_INIT);
        if (bus_done) state_d = S_INIT3;
      end
      S_INIT3: begin
        req_en = 1'b1; req_we = 1'b1;
        req_addr = ADDR_W'(TXEN_ADDR); req_wdata = DATA_W'(1);
        if (bus_done) state_d = S_INIT4;
      end
      S_INIT4: begin
        req_en = 1'b1; req_we = 1'b1;
        req_addr = ADDR_W'(RXEN_ADDR); req_wdata = DATA_W'(RX_EN);
        if (bus_done) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end
      end
      S_IDLE: begin
`ifdef IOB_UART_CTRL_RX_EN
        if (tx_pending && (!rx_elig || !last_tx_q)) begin
          state_d   = S_TX_POLL;
          last_tx_d = 1'b1;
        end else if (rx_elig) begin
          state_d   = S_RX_POLL;
          last_tx_d = 1'b0;
        end
`else
        if (tx_pending) state_d = S_TX_POLL;
`endif
      end
      S_TX_POLL: begin
        req_en = 1'b1;
        req_addr = ADDR_W'(TXREADY_ADDR);
        if (bus_done) state_d = m_rdata[0] ? S_TX_WRITE : S_IDLE;
      end
      S_TX_WRITE: begin
        req_en = 1'b1; req_we = 1'b1;
        req_addr = ADDR_W'(TXDATA_ADDR); req_wdata = DATA_W'(tx_byte_q);
        if (bus_done) begin
          tx_full_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
`ifdef IOB_UART_CTRL_RX_EN
      S_RX_POLL: begin
        req_en = 1'b1;
        req_addr = ADDR_W'(RXREADY_ADDR);
        if (bus_done) state_d = m_rdata[0] ? S_RX_READ : S_IDLE;
      end
      S_RX_READ: begin
        req_en = 1'b1;
        req_addr = ADDR_W'(RXDATA_ADDR);
        if (bus_done) begin
          rx_data_d  = m_rdata[7:0];
          rx_valid_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
`endif
      default: state_d = S_INIT0;
    endcase

    // Issue only from an idle bus; the cycle after m_ready is always idle.
    if (req_en && !m_valid_q) begin
      m_valid_d   = 1'b1;
      m_address_d = req_addr;
      m_wdata_d   = req_wdata;
      m_wstrb_d   = req_we ? '1 : '0;
    end
    if (bus_done) m_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT0;
      m_valid_q   <= 1'b0;
      m_address_q <= '0;
      m_wdata_q   <= '0;
      m_wstrb_q   <= '0;
      tx_full_q   <= 1'b0;
      tx_byte_q   <= '0;
      init_done_q <= 1'b0;
`ifdef IOB_UART_CTRL_RX_EN
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      last_tx_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      m_valid_q   <= m_valid_d;
      m_address_q <= m_address_d;
      m_wdata_q   <= m_wdata_d;
      m_wstrb_q   <= m_wstrb_d;
      tx_full_q   <= tx_full_d;
      tx_byte_q   <= tx_byte_d;
      init_done_q <= init_done_d;
`ifdef IOB_UART_CTRL_RX_EN
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      last_tx_q   <= last_tx_d;
`endif
    end
  end

endmodule

// File: tb/tb_iob_uart_ctrl.sv
// Directed bench for iob_uart_ctrl: a UART slave responder plus byte source/sink,
// with per-scenario tasks checking bus traffic and stream behaviour.

module tb_iob_uart_ctrl;

  localparam logic [3:0] A_SOFT = 4'd0, A_DIV = 4'd1, A_TXD = 4'd2, A_TXEN = 4'd3,
                         A_RXEN = 4'd4, A_TXR = 4'd5, A_RXR = 4'd6, A_RXD = 4'd7;
`ifdef IOB_UART_CTRL_RX_EN
  localparam logic [31:0] RXEN_EXP = 32'd1;
`else
  localparam logic [31:0] RXEN_EXP = 32'd0;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic        m_valid, m_ready = 1'b0;
  logic [3:0]  m_address, m_wstrb;
  logic [31:0] m_wdata, m_rdata = '0;
  logic        tx_valid = 1'b0, tx_ready, rx_valid, rx_ready = 1'b0, init_done;
  logic [7:0]  tx_data = '0, rx_data;

  logic [3:0]  log_addr[$], log_wstrb[$];
  logic [31:0] log_wdata[$], txr_q[$];
  logic [7:0]  tx_q[$], rx_got[$];
  logic [31:0] rxr_val = '0;
  logic [7:0]  rx_next = '0;
  bit          hold_txdata = 1'b0, rx_valid_seen = 1'b0;
  int          rx_addr_seen = 0, stab_err = 0;
  logic        was_valid = 1'b0, was_ready = 1'b0;
  logic [3:0]  pa = '0, ps = '0;
  logic [31:0] pw = '0;
  int          n_cmp = 0, n_bad = 0;

  iob_uart_ctrl dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_address(m_address), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  // Slave responder: m_ready one cycle after m_valid, plus bus-rule watch and tx source.
  always @(negedge clk) begin
    if (m_valid && was_ready) stab_err++;
    if (m_valid && was_valid && !was_ready && {m_address, m_wdata, m_wstrb} !== {pa, pw, ps}) stab_err++;
    if (m_valid && (m_address == A_RXR || m_address == A_RXD)) rx_addr_seen++;
    if (rx_valid === 1'b1) rx_valid_seen = 1'b1;
    if (m_ready) m_ready = 1'b0;
    else if (m_valid && !(hold_txdata && m_address == A_TXD)) begin
      m_ready = 1'b1;
      log_addr.push_back(m_address); log_wdata.push_back(m_wdata); log_wstrb.push_back(m_wstrb);
      case (m_address)
        A_TXR:   if (txr_q.size() > 0) m_rdata = txr_q.pop_front(); else m_rdata = 32'h8000_0001;
        A_RXR:   m_rdata = rxr_val;
        A_RXD:   begin m_rdata = {24'hFFFFFF, rx_next}; rx_next = rx_next + 8'd1; end
        default: m_rdata = 32'hDEAD_BEE0;
      endcase
    end
    was_valid = m_valid; was_ready = m_ready; pa = m_address; pw = m_wdata; ps = m_wstrb;
    if (tx_q.size() > 0) begin tx_valid = 1'b1; tx_data = tx_q[0]; end
    else begin tx_valid = 1'b0; tx_data = 8'h00; end
  end

  // Handshakes are observed with pre-edge values.
  always @(posedge clk) begin
    if (tx_valid && tx_ready && tx_q.size() > 0) void'(tx_q.pop_front());
    if (rx_valid && rx_ready) rx_got.push_back(rx_data);
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic clear_log();
    log_addr.delete(); log_wdata.delete(); log_wstrb.delete();
  endtask

  function automatic int count_addr(input logic [3:0] a);
    int n = 0;
    foreach (log_addr[i]) if (log_addr[i] == a) n++;
    return n;
  endfunction

  task automatic do_reset_init();
    rst = 1'b1; hold_txdata = 1'b0; tx_q.delete(); txr_q.delete(); rx_got.delete();
    repeat (3) step();
    clear_log(); rst = 1'b0;
    for (int k = 0; k < 100 && !init_done; k++) step();
    n_cmp++; if (init_done !== 1'b1) begin n_bad++; $display("FAIL reinit_timeout: init_done=%b want 1", init_done); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
    n_cmp++; if (m_address !== 4'h0) begin n_bad++; $display("FAIL rst_m_address: got %h want 0", m_address); end
    n_cmp++; if (m_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_m_wdata: got %h want 0", m_wdata); end
    n_cmp++; if (m_wstrb !== 4'h0) begin n_bad++; $display("FAIL rst_m_wstrb: got %h want 0", m_wstrb); end
    n_cmp++; if (tx_ready !== 1'b0) begin n_bad++; $display("FAIL rst_tx_ready: got %b want 0", tx_ready); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rx_valid: got %b want 0", rx_valid); end
    n_cmp++; if (rx_data !== 8'h0) begin n_bad++; $display("FAIL rst_rx_data: got %h want 0", rx_data); end
    n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL rst_init_done: got %b want 0", init_done); end
  endtask

  task automatic test_init();
    logic [3:0]  ea[5];
    logic [31:0] ew[5];
    ea = '{A_SOFT, A_SOFT, A_DIV, A_TXEN, A_RXEN};
    ew = '{32'd1, 32'd0, 32'd868, 32'd1, RXEN_EXP};
    clear_log(); rst = 1'b0;
    for (int k = 0; k < 100 && log_addr.size() < 5; k++) step();
    n_cmp++; if (log_addr.size() != 5) begin n_bad++; $display("FAIL init_count: got %0d writes want 5", log_addr.size()); end
    n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL init_done_early: got %b want 0", init_done); end
    n_cmp++; if (tx_ready !== 1'b0) begin n_bad++; $display("FAIL init_tx_ready_early: got %b want 0", tx_ready); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (i >= log_addr.size() || log_addr[i] !== ea[i] || log_wdata[i] !== ew[i] || log_wstrb[i] !== 4'hF) begin
        n_bad++;
        if (i < log_addr.size())
          $display("FAIL init_write%0d: got a=%h d=%h s=%h want a=%h d=%h s=f", i, log_addr[i], log_wdata[i], log_wstrb[i], ea[i], ew[i]);
        else $display("FAIL init_write%0d: missing want a=%h d=%h", i, ea[i], ew[i]);
      end
    end
    step();
    n_cmp++; if (init_done !== 1'b1) begin n_bad++; $display("FAIL init_done_rise: got %b want 1", init_done); end
    n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL init_tx_ready: got %b want 1", tx_ready); end
  endtask

  task automatic test_tx_poll();
    logic [3:0]  fa[$], fs[$];
    logic [31:0] fw[$];
    logic [3:0]  ea[4];
    ea = '{A_TXR, A_TXR, A_TXR, A_TXD};
    clear_log();
    txr_q.push_back(32'hFFFF_FFFE); txr_q.push_back(32'h0000_0002);
    tx_q.push_back(8'h5A);
    for (int k = 0; k < 300 && !(m_ready && log_addr.size() > 0 && log_addr[$] == A_TXD); k++) step();
    n_cmp++; if (count_addr(A_TXD) != 1) begin n_bad++; $display("FAIL tx_write_seen: got %0d want 1", count_addr(A_TXD)); end
    n_cmp++; if (tx_ready !== 1'b0) begin n_bad++; $display("FAIL tx_ready_busy: got %b want 0", tx_ready); end
    foreach (log_addr[i])
      if (log_addr[i] == A_TXR || log_addr[i] == A_TXD) begin
        fa.push_back(log_addr[i]); fw.push_back(log_wdata[i]); fs.push_back(log_wstrb[i]);
      end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= fa.size() || fa[i] !== ea[i] || fs[i] !== ((i == 3) ? 4'hF : 4'h0)) begin
        n_bad++; $display("FAIL tx_seq%0d: got a=%h want a=%h", i, (i < fa.size()) ? fa[i] : 4'hF, ea[i]);
      end
    end
    n_cmp++; if (fw.size() < 4 || fw[3] !== 32'h0000_005A) begin n_bad++; $display("FAIL tx_wdata: got %h want 0000005a", (fw.size() > 3) ? fw[3] : 32'hX); end
    step();
    n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL tx_ready_back: got %b want 1", tx_ready); end
  endtask

`ifdef IOB_UART_CTRL_RX_EN
  task automatic test_rx_hold();
    rx_ready = 1'b0; rx_next = 8'hA5; clear_log(); rxr_val = 32'h1;
    for (int k = 0; k < 100 && !rx_valid; k++) step();
    n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL rx_valid_rise: got %b want 1", rx_valid); end
    n_cmp++; if (rx_data !== 8'hA5) begin n_bad++; $display("FAIL rx_data: got %h want a5", rx_data); end
    repeat (30) step();
    n_cmp++; if (count_addr(A_RXR) != 1) begin n_bad++; $display("FAIL rx_no_repoll: got %0d polls want 1", count_addr(A_RXR)); end
    n_cmp++; if (count_addr(A_RXD) != 1) begin n_bad++; $display("FAIL rx_one_read: got %0d reads want 1", count_addr(A_RXD)); end
    n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL rx_held: got %b want 1", rx_valid); end
    rx_ready = 1'b1; step(); rx_ready = 1'b0; rxr_val = 32'h0; step();
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL rx_cleared: got %b want 0", rx_valid); end
    for (int k = 0; k < 60 && count_addr(A_RXR) < 2; k++) step();
    n_cmp++; if (count_addr(A_RXR) < 2) begin n_bad++; $display("FAIL rx_repoll: got %0d polls want >=2", count_addr(A_RXR)); end
  endtask
`endif

  task automatic test_back_to_back();
    logic [7:0] got_tx[$];
    logic [3:0] pq[$];
    rst = 1'b1; hold_txdata = 1'b0; tx_q.delete(); txr_q.delete();
    step();
    for (int i = 0; i < 16; i++) tx_q.push_back(8'(i * 37 + 11));
    rxr_val = 32'h1; rx_next = 8'h30; rx_ready = 1'b1; rx_got.delete();
    step(); clear_log(); rst = 1'b0;
`ifdef IOB_UART_CTRL_RX_EN
    for (int k = 0; k < 3000 && (count_addr(A_TXD) < 16 || rx_got.size() < 16); k++) step();
`else
    for (int k = 0; k < 3000 && count_addr(A_TXD) < 16; k++) step();
`endif
    rxr_val = 32'h0;
    foreach (log_addr[i]) begin
      if (log_addr[i] == A_TXD) got_tx.push_back(log_wdata[i][7:0]);
      if (log_addr[i] == A_TXR || log_addr[i] == A_RXR) pq.push_back(log_addr[i]);
    end
    n_cmp++; if (got_tx.size() != 16) begin n_bad++; $display("FAIL b2b_tx_count: got %0d want 16", got_tx.size()); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (i >= got_tx.size() || got_tx[i] !== 8'(i * 37 + 11)) begin
        n_bad++; $display("FAIL b2b_tx%0d: got %h want %h", i, (i < got_tx.size()) ? got_tx[i] : 8'hXX, 8'(i * 37 + 11));
      end
    end
`ifdef IOB_UART_CTRL_RX_EN
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (i >= rx_got.size() || rx_got[i] !== 8'(8'h30 + i)) begin
        n_bad++; $display("FAIL b2b_rx%0d: got %h want %h", i, (i < rx_got.size()) ? rx_got[i] : 8'hXX, 8'(8'h30 + i));
      end
    end
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (i >= pq.size() || pq[i] !== ((i % 2 == 0) ? A_TXR : A_RXR)) begin
        n_bad++; $display("FAIL b2b_order%0d: got a=%h want a=%h", i, (i < pq.size()) ? pq[i] : 4'hF, (i % 2 == 0) ? A_TXR : A_RXR);
      end
    end
`endif
    rx_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset_init();
    hold_txdata = 1'b1; tx_q.push_back(8'h77);
    for (int k = 0; k < 100 && !(m_valid && m_address == A_TXD); k++) step();
    repeat (3) step();
    n_cmp++; if (!(m_valid === 1'b1 && m_address === A_TXD)) begin n_bad++; $display("FAIL mid_txdata_held: got v=%b a=%h want v=1 a=2", m_valid, m_address); end
    rst = 1'b1; step();
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL mid_m_valid: got %b want 0", m_valid); end
    n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL mid_init_done: got %b want 0", init_done); end
    n_cmp++; if (tx_ready !== 1'b0) begin n_bad++; $display("FAIL mid_tx_ready: got %b want 0", tx_ready); end
    hold_txdata = 1'b0; clear_log(); rst = 1'b0;
    for (int k = 0; k < 100 && !init_done; k++) step();
    n_cmp++; if (log_addr.size() < 1 || log_addr[0] !== A_SOFT || log_wdata[0] !== 32'd1) begin n_bad++; $display("FAIL mid_restart: first write not SOFTRESET=1 (n=%0d)", log_addr.size()); end
    n_cmp++; if (init_done !== 1'b1) begin n_bad++; $display("FAIL mid_reinit: got %b want 1", init_done); end
    repeat (40) step();
    n_cmp++; if (count_addr(A_TXD) != 0) begin n_bad++; $display("FAIL mid_byte_dropped: got %0d writes want 0", count_addr(A_TXD)); end
  endtask

  task automatic test_final();
`ifndef IOB_UART_CTRL_RX_EN
    n_cmp++; if (rx_addr_seen != 0) begin n_bad++; $display("FAIL norx_addr: got %0d rx accesses want 0", rx_addr_seen); end
    n_cmp++; if (rx_valid_seen) begin n_bad++; $display("FAIL norx_valid: rx_valid seen high, want never"); end
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL norx_data: got %h want 0", rx_data); end
`endif
    n_cmp++; if (stab_err != 0) begin n_bad++; $display("FAIL bus_rule: got %0d violations want 0", stab_err); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_tx_poll();
`ifdef IOB_UART_CTRL_RX_EN
    test_rx_hold();
`endif
    test_back_to_back();
    test_reset_mid();
    test_final();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/iob_uart_ctrl.md
Name: iob_uart_ctrl

Overview:
- Hardware IOb-native bus master that drives a UART peripheral's register interface: initialises it, then moves bytes between local byte streams and the UART.
- Replaces CPU software for UART I/O in CPU-less subsystems, such as boot loaders and debug bridges.
- Sits between a byte producer/consumer and the UART slave port.

Parameters:
- DATA_W, 32: bus data width (32 or 64).
- ADDR_W, 4: bus address width.
- DIV_INIT, 868: value written to UART_DIV at init (clock cycles per bit).
- SOFTRESET_ADDR, 0; DIV_ADDR, 1; TXDATA_ADDR, 2; TXEN_ADDR, 3; RXEN_ADDR, 4; TXREADY_ADDR, 5; RXREADY_ADDR, 6; RXDATA_ADDR, 7: UART register addresses. These must match the slave register map.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- m_valid  out  1  bus request
- m_address  out  ADDR_W  request address
- m_wdata  out  DATA_W  write data
- m_wstrb  out  DATA_W/8  write strobes; all ones for writes, zero for reads
- m_rdata  in  DATA_W  read data, valid when m_ready=1
- m_ready  in  1  transaction complete
- tx_valid  in  1  byte to transmit offered
- tx_data  in  8  byte to transmit
- tx_ready  out  1  tx byte accepted this cycle
- rx_valid  out  1  received byte available
- rx_data  out  8  received byte
- rx_ready  in  1  consumer accepts rx byte
- init_done  out  1  init sequence complete

Behaviour:
- Reset: m_valid=0, m_address=0, m_wdata=0, m_wstrb=0, tx_ready=0, rx_valid=0, rx_data=0, init_done=0. State goes to INIT0.
- Bus rule: one transaction at a time. m_valid, m_address, m_wdata and m_wstrb are registered and held stable until the cycle m_ready=1. m_valid drops the cycle after m_ready. Minimum one idle cycle between transactions.
- m_ready while m_valid=0 is ignored. No timeout.
- Init sequence, one write per state:
  - INIT0: SOFTRESET=1
  - INIT1: SOFTRESET=0
  - INIT2: DIV=DIV_INIT
  - INIT3: TXEN=1
  - INIT4: RXEN=1
  - After INIT4 completes, init_done=1 (sticky until rst) and state goes to IDLE.
- tx_ready stays 0 until init_done=1.
- IDLE arbitration:
  - TX service is eligible when a byte is held in the tx holding register.
  - RX service is eligible when the rx output register is empty.
  - If both are eligible, alternate with round-robin; the first grant after init goes to TX.
- TX_POLL: read TXREADY_ADDR.
  - m_rdata[0]=0: return to IDLE, which re-arbitrates.
  - m_rdata[0]=1: go to TX_WRITE.
- TX_WRITE: write TXDATA_ADDR with wdata = zero-extended held byte. On m_ready, clear the holding register and go to IDLE.
- tx holding register: one byte. tx_ready = init_done AND holding empty, combinational. The byte is captured when tx_valid AND tx_ready.
- RX_POLL: read RXREADY_ADDR.
  - m_rdata[0]=1: go to RX_READ.
  - Otherwise: go to IDLE.
- RX_READ: read RXDATA_ADDR. On m_ready, rx_data = m_rdata[7:0] and rx_valid=1 from the next cycle. Go to IDLE.
- rx output register: rx_valid is cleared on rx_valid AND rx_ready. It is never overwritten while full, because RX is not eligible when full.
- Capture and clear on the same cycle: a tx holding register can be filled in the cycle after it is cleared, not the same cycle. A simultaneous rx clear and capture cannot occur.
- rst asserted mid-transaction: m_valid drops the next cycle, all buffered bytes are discarded, and init restarts.
- Upper m_rdata bits are ignored.

Optional Feature:
- IOB_UART_CTRL_RX_EN
- Defined: full RX path as above; INIT4 writes RXEN=1.
- Undefined:
  - RX_POLL and RX_READ states are absent.
  - INIT4 writes RXEN=0.
  - rx_valid is tied to 0 and rx_data to 0; rx_ready is ignored.
  - Arbitration is TX only.

Test Plan:
- Reset, then a responder with m_ready one cycle after m_valid. Required: five writes in order SOFTRESET=1, SOFTRESET=0, DIV=868, TXEN=1, RXEN=1, all with m_wstrb all ones. init_done rises after the fifth m_ready.
- tx_valid with 0x5A while the responder returns TXREADY=0 twice, then 1. Required: three TXREADY reads, then a TXDATA write with wdata=0x0000005A. tx_ready reasserts after the write completes.
- Responder returns RXREADY=1 and RXDATA=0xFFFFFFA5, with rx_ready held 0. Required: rx_valid=1 with rx_data=0xA5, and no further RXREADY polls until rx_ready pulses.
- Continuous tx_valid plus RXREADY=1 always. Required: TX and RX services strictly alternate, TX first. No byte is lost over 16 bytes each way.
- rst asserted during the TXDATA write with m_ready withheld. Required: m_valid=0 next cycle, the held byte is dropped, the init sequence restarts, and init_done=0.
- With IOB_UART_CTRL_RX_EN undefined: INIT4 writes RXEN=0, no RXREADY or RXDATA addresses ever appear, and rx_valid stays 0.
